alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
Sequential command front-end that drives the combinational 16-bit ALU and collects its outputs. It accepts ALU commands over a valid/ready handshake and registers the operands onto the ALU inputs. It then captures result and flags into a response buffer and keeps a persistent flags register. That register feeds a branch-condition evaluator. The block sits between the control unit and the ALU.

Parameters:
DATA_W, 16, operand/result width; must match the ALU (16).
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command this cycle.
cmd_sel  in  3  ALU op: 0 PLUS, 1 MINUS, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SAR.
cmd_a  in  DATA_W  operand A.
cmd_b  in  DATA_W  operand B (shift amount for 5-7).
alu_sel  out  3  registered op to the ALU.
alu_a  out  DATA_W  registered operand A to the ALU.
alu_b  out  DATA_W  registered operand B to the ALU.
alu_result  in  DATA_W  ALU result.
alu_flags  in  4  ALU flags {C,V,N,Z}.
rsp_valid  out  1  response held.
rsp_ready  in  1  consumer takes the response.
rsp_result  out  DATA_W  captured result.
rsp_flags  out  4  captured flags.
flags_q  out  4  persistent flags register {C,V,N,Z}.
cond_sel  in  3  condition select.
cond_true  out  1  condition evaluated on flags_q.
ops_done  out  CNT_W  count of completed operations.

Behaviour:
- Reset values, applied asynchronously while rst_n=0:
  - state=IDLE.
  - cmd_ready=0 while in reset; 1 once in IDLE.
  - alu_sel/alu_a/alu_b=0.
  - rsp_valid=0, rsp_result=0, rsp_flags=0.
  - flags_q=0, ops_done=0.
- FSM states are IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_sel/a/b into alu_sel/a/b, go to EXEC.
- EXEC: exactly one cycle, cmd_ready=0. At the end-of-cycle edge:
  - rsp_result<=alu_result, rsp_flags<=alu_flags, flags_q<=alu_flags.
  - ops_done<=ops_done+1, wrapping modulo 2^CNT_W.
  - rsp_valid<=1, go to RESP.
- RESP:
  - rsp_result and rsp_flags are held stable while rsp_valid&&!rsp_ready.
  - cmd_ready=rsp_ready.
  - Handshake with cmd_valid=0: rsp_valid<=0, go to IDLE.
  - Handshake with cmd_valid=1 (simultaneous): latch the new command, rsp_valid<=0, go straight to EXEC. No bubble.
- Latency: command accepted at edge k; rsp_valid is high after edge k+1. Throughput is one op per 2 cycles under back-to-back load.
- alu_sel/a/b hold their last value outside of command acceptance.
- cond_true is combinational from flags_q only:
  - 0 always, 1 Z, 2 !Z, 3 C (unsigned lower/borrow), 4 !C, 5 N, 6 V, 7 N^V (signed less).
- flags_q updates only in EXEC, never on response handshake.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, no response, all outputs return to reset values.
- cmd_valid while cmd_ready=0 is ignored; the command must be held by the source.

Optional Feature:
ALU_ISSUER_CMP_EN:
- Defined:
  - Adds input cmd_flags_only (1 bit), latched with the command.
  - A flags-only op in EXEC updates flags_q and ops_done but not rsp_result/rsp_flags/rsp_valid. The FSM returns to IDLE, so cmp-style ops need no consumer.
- Undefined: the port is absent and every op produces a response.

Test Plan:
1. cmd 0x7FFF PLUS 0x7FFF, rsp_ready=1 -> rsp_valid 1 cycle after accept, rsp_result=0xFFFE, rsp_flags=0110; cond_sel=6 -> cond_true=1; ops_done=1.
2. cmd 0xFFFF PLUS 0x0001 -> rsp_result=0, flags 1001; cond_sel=1 -> 1, cond_sel=2 -> 0.
3. cmd 30 MINUS 40, rsp_ready=0 for 5 cycles -> rsp_result=0xFFF6 and flags 1010 held stable; cmd_ready=0 throughout; cond_sel=3 -> 1. Then rsp_ready=1 -> IDLE.
4. Back-to-back: 0xC000 SAR 3 queued while RESP handshakes -> no bubble, result 0xF800, flags 0010; then 0x0006 SHL 3 -> 0x0030, flags 0000; ops_done increments by 2.
5. Assert rst_n=0 during EXEC of 0x8000 MINUS 1 -> no response, flags_q=0, ops_done=0; after release, cmd_ready=1 in IDLE.
6. (ALU_ISSUER_CMP_EN) flags-only 30 MINUS 30 -> rsp_valid stays 0, flags_q=0001, ops_done+1, back in IDLE next cycle.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command front-end for the 16-bit ALU: valid/ready command intake, registered ALU operands,
// response buffer, persistent flags and branch-condition evaluation. Optional: ALU_ISSUER_CMP_EN.
module alu_cmd_issuer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_sel,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
`ifdef ALU_ISSUER_CMP_EN
  input  logic              cmd_flags_only,
`endif
  output logic [2:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [3:0]        flags_q,
  input  logic [2:0]        cond_sel,
  output logic              cond_true,
  output logic [CNT_W-1:0]  ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;
  } rsp_t;

  state_t state, state_d;
  rsp_t   rsp_q;
  logic   accept;
  logic   exec_fo;

`ifdef ALU_ISSUER_CMP_EN
  logic fo_q;
  assign exec_fo = fo_q;
`else
  assign exec_fo = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: cmd_ready = 1'b1;
      EXEC: state_d = exec_fo ? IDLE : RESP;
      RESP: begin
        cmd_ready = rsp_ready;
        if (rsp_ready) state_d = cmd_valid ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // IDLE is the reset state, so readiness is held off until reset is released
    cmd_ready = cmd_ready & rst_n;
    accept    = cmd_valid & cmd_ready;
    if (state == IDLE && accept) state_d = EXEC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      flags_q   <= '0;
      ops_done  <= '0;
`ifdef ALU_ISSUER_CMP_EN
      fo_q      <= 1'b0;
`endif
    end else begin
      state <= state_d;
      if (accept) begin
        alu_sel <= cmd_sel;
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
`ifdef ALU_ISSUER_CMP_EN
        fo_q    <= cmd_flags_only;
`endif
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
      if (state == EXEC) begin
        flags_q  <= alu_flags;
        ops_done <= ops_done + CNT_W'(1);
        if (!exec_fo) begin
          rsp_q     <= '{result: alu_result, flags: alu_flags};
          rsp_valid <= 1'b1;
        end
      end
    end
  end

  assign rsp_result = rsp_q.result;
  assign rsp_flags  = rsp_q.flags;

  // flags_q = {C,V,N,Z}
  always_comb begin
    case (cond_sel)
      3'd0:    cond_true = 1'b0;
      3'd1:    cond_true = flags_q[0];
      3'd2:    cond_true = ~flags_q[0];
      3'd3:    cond_true = flags_q[3];
      3'd4:    cond_true = ~flags_q[3];
      3'd5:    cond_true = flags_q[1+1];
      3'd6:    cond_true = flags_q[1];
      default: cond_true = flags_q[2] ^ flags_q[1];
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: behavioural ALU, transaction-level reference model,
// directed test-plan cases and randomized traffic with occasional mid-operation resets.
module tb_alu_cmd_issuer;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_sel;
  logic [DW-1:0] cmd_a, cmd_b;
  logic          fo_in;
  logic [2:0]    alu_sel;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    alu_flags;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_flags, flags_q;
  logic [2:0]    cond_sel;
  logic          cond_true;
  logic [CW-1:0] ops_done;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef ALU_ISSUER_CMP_EN
    .cmd_flags_only(fo_in),
`endif
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .flags_q(flags_q), .cond_sel(cond_sel), .cond_true(cond_true),
    .ops_done(ops_done)
  );

  // returns {C,V,N,Z,result}
  function automatic logic [19:0] alu_f(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; w = '0; r = '0;
    case (s)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0];
        c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[3:0];
      3'd6: r = a >> b[3:0];
      default: r = 16'($signed(a) >>> b[3:0]);
    endcase
    return {c, v, r[15], (r == 16'd0), r};
  endfunction

  function automatic logic cond_f(input logic [3:0] f, input logic [2:0] s);
    case (s)
      3'd0: return 1'b0;
      3'd1: return f[0];
      3'd2: return !f[0];
      3'd3: return f[3];
      3'd4: return !f[3];
      3'd5: return f[2];
      3'd6: return f[1];
      default: return f[2] ^ f[1];
    endcase
  endfunction

  always_comb {alu_flags, alu_result} = alu_f(alu_sel, alu_a, alu_b);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: an op completes one edge after acceptance; its response
  // persists until handshaken
  logic          in_exec, ex_fo, exp_rv, last_acc;
  logic [19:0]   ex_res;
  logic [2:0]    ex_sel;
  logic [DW-1:0] ex_a, ex_b, exp_rr;
  logic [3:0]    exp_rf, flags_m;
  logic [CW-1:0] cnt_m;

  task automatic model_clear();
    in_exec = 1'b0; ex_fo = 1'b0; exp_rv = 1'b0; last_acc = 1'b0;
    ex_res = '0; ex_sel = '0; ex_a = '0; ex_b = '0;
    exp_rr = '0; exp_rf = '0; flags_m = '0; cnt_m = '0;
  endtask

  task automatic cyc();
    logic exp_ready, acc, hs;
    @(negedge clk);
    exp_ready = !in_exec && (!exp_rv || rsp_ready);
    chk("cmd_ready", cmd_ready, exp_ready);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      chk("rsp_result", rsp_result, exp_rr);
      chk("rsp_flags", rsp_flags, exp_rf);
    end
    chk("flags_q", flags_q, flags_m);
    chk("ops_done", ops_done, cnt_m);
    chk("cond_true", cond_true, cond_f(flags_m, cond_sel));
    if (in_exec) begin
      chk("alu_sel", alu_sel, ex_sel);
      chk("alu_a", alu_a, ex_a);
      chk("alu_b", alu_b, ex_b);
    end
    acc = cmd_valid && exp_ready;
    hs  = exp_rv && rsp_ready;
    @(posedge clk);
    if (hs) exp_rv = 1'b0;
    if (in_exec) begin
      cnt_m   = cnt_m + 1'b1;
      flags_m = ex_res[19:16];
      if (!ex_fo) begin
        exp_rv = 1'b1;
        exp_rr = ex_res[15:0];
        exp_rf = ex_res[19:16];
      end
    end
    in_exec = acc;
    if (acc) begin
      ex_sel = cmd_sel; ex_a = cmd_a; ex_b = cmd_b;
      ex_res = alu_f(cmd_sel, cmd_a, cmd_b);
      ex_fo  = fo_in;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_result"}, rsp_result, '0);
    chk({tag, "_rsp_flags"}, rsp_flags, '0);
    chk({tag, "_flags_q"}, flags_q, '0);
    chk({tag, "_ops_done"}, ops_done, '0);
    chk({tag, "_alu_sel"}, alu_sel, '0);
    chk({tag, "_alu_a"}, alu_a, '0);
    chk({tag, "_alu_b"}, alu_b, '0);
  endtask

  // called just after a rising edge; reset asserts mid-cycle
  task automatic rst_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1 rst_chk(tag);
    model_clear();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk({tag, "_idle_ready"}, cmd_ready, 1'b1);
  endtask

  task automatic issue(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    cmd_sel = s; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (last_acc) break;
    end
    if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  logic [CW-1:0] base;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0;
    fo_in = 1'b0; rsp_ready = 1'b0; cond_sel = '0;
    model_clear();
    #1 rst_chk("por");
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("por_idle_ready", cmd_ready, 1'b1);

    // signed overflow on add
    cond_sel = 3'd6; rsp_ready = 1'b1;
    issue(3'd0, 16'h7FFF, 16'h7FFF);
    cyc();
    chk("t1_res", rsp_result, 16'hFFFE);
    chk("t1_flags", rsp_flags, 4'b0110);
    chk("t1_cond", cond_true, 1'b1);
    chk("t1_ops", ops_done, 1);
    cyc();

    // carry out to zero
    issue(3'd0, 16'hFFFF, 16'h0001);
    cyc();
    chk("t2_res", rsp_result, 16'h0000);
    chk("t2_flags", rsp_flags, 4'b1001);
    cond_sel = 3'd1;
    #1 chk("t2_cond_z", cond_true, 1'b1);
    cond_sel = 3'd2;
    #1 chk("t2_cond_nz", cond_true, 1'b0);
    cyc();

    // borrow with back-pressure
    rsp_ready = 1'b0; cond_sel = 3'd3;
    issue(3'd1, 16'd30, 16'd40);
    cyc();
    repeat (5) begin
      chk("t3_res", rsp_result, 16'hFFF6);
      chk("t3_flags", rsp_flags, 4'b1010);
      chk("t3_cmd_ready", cmd_ready, 1'b0);
      chk("t3_cond", cond_true, 1'b1);
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    chk("t3_idle", cmd_ready, 1'b1);

    // back-to-back, no bubble
    issue(3'd0, 16'd1, 16'd1);
    cyc();
    base = ops_done;
    issue(3'd7, 16'hC000, 16'd3);
    cyc();
    chk("t4_sar_res", rsp_result, 16'hF800);
    chk("t4_sar_flags", rsp_flags, 4'b0010);
    issue(3'd5, 16'h0006, 16'd3);
    cyc();
    chk("t4_shl_res", rsp_result, 16'h0030);
    chk("t4_shl_flags", rsp_flags, 4'b0000);
    chk("t4_ops", ops_done, base + CW'(2));
    cyc();

    // reset during EXEC
    issue(3'd1, 16'h8000, 16'h0001);
    rst_pulse("t5");

`ifdef ALU_ISSUER_CMP_EN
    fo_in = 1'b1;
    issue(3'd1, 16'd30, 16'd30);
    fo_in = 1'b0;
    cyc();
    chk("t6_rsp_valid", rsp_valid, 1'b0);
    chk("t6_flags_q", flags_q, 4'b0001);
    chk("t6_ops", ops_done, 1);
    chk("t6_idle", cmd_ready, 1'b1);
`endif

    // randomized traffic; commands held until accepted
    for (int i = 0; i < 3000; i++) begin
      if (!cmd_valid || last_acc) begin
        cmd_valid = ($urandom_range(0, 9) < 7);
        cmd_sel   = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: cmd_a = 16'h8000;
          1: cmd_a = 16'h7FFF;
          default: cmd_a = 16'($urandom);
        endcase
        cmd_b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
`ifdef ALU_ISSUER_CMP_EN
        fo_in = ($urandom_range(0, 3) == 0);
`endif
      end
      rsp_ready = ($urandom_range(0, 9) < 6);
      cond_sel  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        rst_pulse("rnd_rst");
        cmd_valid = 1'b0;
      end else begin
        cyc();
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
